bomb_countdown_timer: RTL

- Countdown timer for each bomb level; sits directly downstream of the RAM controller.
- Consumes the controller's `cur_level` and the game controller's `game_state`.
- Loads a per-level starting time, counts down once per second, and applies strike penalties.
- Drives BCD digits to the 7-segment display and an `expired` flag back to the game controller.

---
 rtl/bomb_countdown_timer.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/bomb_countdown_timer.sv
// Per-level bomb countdown: loads a start time, ticks once per second, applies strike
// penalties, and presents the remaining seconds as BCD through a sequential converter.
module bomb_countdown_timer #(
  parameter int CLK_HZ    = 50000000,
  parameter int BASE_TIME = 300,
  parameter int STEP_TIME = 10,
  parameter int MIN_TIME  = 60,
  parameter int PENALTY   = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] game_state,
  input  logic [7:0] cur_level,
  input  logic       strike,
  output logic [3:0] time_hund,
  output logic [3:0] time_tens,
  output logic [3:0] time_ones,
  output logic       running,
  output logic       expired,
  output logic       sec_tick
);

  localparam int              PS_W      = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PS_W-1:0] LP_PS_MAX = PS_W'(CLK_HZ - 1);
  localparam logic [15:0]     LP_BASE   = 16'(BASE_TIME);
  localparam logic [15:0]     LP_STEP   = 16'(STEP_TIME);
  localparam logic [15:0]     LP_MIN    = 16'(MIN_TIME);
  localparam logic [9:0]      LP_PEN    = 10'(PENALTY);

  localparam logic [7:0] GS_IDLE  = 8'h00;
  localparam logic [7:0] GS_PLAY  = 8'h10;
  localparam logic [7:0] GS_DONE  = 8'h20;
  localparam logic [7:0] GS_OVER  = 8'h30;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_HOLD, S_EXPIRED} state_t;

  state_t          r_state;
  state_t          w_next_state;
  logic [7:0]      r_prev_state;
  logic [PS_W-1:0] r_prescaler;
  logic [9:0]      r_remaining;
  logic [9:0]      w_rem_next;
  logic            r_running;
  logic            r_expired;
  logic            r_sec_tick;
  logic            w_running_next;
  logic            w_expired_next;
  logic            w_start_evt;
  logic            w_tick;
  logic [9:0]      w_dec;

  logic [15:0]     w_prod;
  logic [15:0]     w_diff;
  logic [15:0]     w_start16;
  logic [9:0]      w_start;

  logic            r_conv_busy;
  logic [3:0]      r_conv_cnt;
  logic [9:0]      r_conv_bin;
  logic [10:0]     r_conv_bcd;
  logic [10:0]     w_adj;
  logic [11:0]     w_bcd_shift;
  logic [11:0]     r_digits;

  assign w_start_evt = (game_state == GS_PLAY) && (r_prev_state != GS_PLAY);

  // Start time: underflow or short result falls back to the floor, then display clamp.
  assign w_prod    = 16'(cur_level) * LP_STEP;
  assign w_diff    = LP_BASE - w_prod;
  assign w_start16 = ((w_prod > LP_BASE) || (w_diff < LP_MIN)) ? LP_MIN : w_diff;
  assign w_start   = (w_start16 > 16'd999) ? 10'd999 : w_start16[9:0];

  assign w_tick = (r_state == S_RUN) && (r_prescaler == LP_PS_MAX) && (r_remaining != 10'd0);
  assign w_dec  = {9'd0, w_tick} + ((strike && (r_state == S_RUN)) ? LP_PEN : 10'd0);

  always_comb begin
    w_rem_next = r_remaining;
    if (w_next_state == S_LOAD)
      w_rem_next = w_start;
    else if (r_state == S_RUN)
      w_rem_next = (r_remaining > w_dec) ? (r_remaining - w_dec) : 10'd0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_prev_state <= GS_IDLE;
      r_running    <= 1'b0;
      r_expired    <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_prev_state <= game_state;
      r_running    <= w_running_next;
      r_expired    <= w_expired_next;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:    w_next_state = S_IDLE;
      S_LOAD:    w_next_state = S_RUN;
      S_RUN: begin
        if (r_remaining == 10'd0)
          w_next_state = S_EXPIRED;
        else if ((game_state == GS_DONE) || (game_state == GS_OVER))
          w_next_state = S_HOLD;
        else if (game_state == GS_IDLE)
          w_next_state = S_IDLE;
      end
      S_HOLD:    if (game_state == GS_IDLE) w_next_state = S_IDLE;
      S_EXPIRED: if (game_state != GS_PLAY) w_next_state = S_IDLE;
      default:   w_next_state = S_IDLE;
    endcase
    if (w_start_evt && (r_state != S_LOAD))
      w_next_state = S_LOAD;
  end

  always_comb begin
    w_running_next = (w_next_state == S_RUN);
    w_expired_next = (w_next_state == S_EXPIRED);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_prescaler <= '0;
      r_remaining <= 10'd0;
      r_sec_tick  <= 1'b0;
    end else begin
      r_remaining <= w_rem_next;
      r_sec_tick  <= w_tick && (w_next_state != S_LOAD);
      if ((w_next_state == S_LOAD) || (r_state == S_LOAD) || (r_state == S_IDLE))
        r_prescaler <= '0;
      else if (r_state == S_RUN)
        r_prescaler <= (r_prescaler == LP_PS_MAX) ? '0 : (r_prescaler + 1'b1);
    end
  end

  // Double-dabble: add-3 on each BCD digit >= 5, then shift one binary bit in.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_adj
      assign w_adj[gi*4 +: 4] = (r_conv_bcd[gi*4 +: 4] >= 4'd5) ?
                                (r_conv_bcd[gi*4 +: 4] + 4'd3) : r_conv_bcd[gi*4 +: 4];
    end
  endgenerate
  assign w_adj[10:8]  = (r_conv_bcd[10:8] >= 3'd5) ? (r_conv_bcd[10:8] + 3'd3) : r_conv_bcd[10:8];
  assign w_bcd_shift  = {w_adj, r_conv_bin[9]};

  // A conversion finishing on the same edge as a new change still publishes its result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_conv_busy <= 1'b0;
      r_conv_cnt  <= 4'd0;
      r_conv_bin  <= 10'd0;
      r_conv_bcd  <= 11'd0;
      r_digits    <= 12'd0;
    end else begin
      if (r_conv_busy && (r_conv_cnt == 4'd9))
        r_digits <= w_bcd_shift;
      if (w_rem_next != r_remaining) begin
        r_conv_busy <= 1'b1;
        r_conv_cnt  <= 4'd0;
        r_conv_bin  <= w_rem_next;
        r_conv_bcd  <= 11'd0;
      end else if (r_conv_busy) begin
        r_conv_bin  <= {r_conv_bin[8:0], 1'b0};
        r_conv_bcd  <= w_bcd_shift[10:0];
        r_conv_cnt  <= r_conv_cnt + 4'd1;
        if (r_conv_cnt == 4'd9)
          r_conv_busy <= 1'b0;
      end
    end
  end

  assign time_hund = r_digits[11:8];
  assign time_tens = r_digits[7:4];
  assign time_ones = r_digits[3:0];
  assign running   = r_running;
  assign expired   = r_expired;
  assign sec_tick  = r_sec_tick;

endmodule
